// File: rtl/pmu_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmu_cfg_pkg
// Description : Shared PMU configuration-load types and widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pmu_cfg_pkg;

    localparam int BLOCK_W   = 128;
    localparam int CNT_W_DEF = 20;   // also used by the PMU header decoder
    localparam int BITS_W    = 8;    // holds 0..BLOCK_W

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESET = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/ccff_block_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : ccff_block_serializer_if
// Description : Plaintext block valid/ready channel from the AES result port.
// Revision    : 1.0 - initial release
// ============================================================================
interface ccff_block_serializer_if;

    logic                             blk_valid;
    logic [pmu_cfg_pkg::BLOCK_W-1:0]  blk_data;
    logic                             blk_ready;

    modport master (output blk_valid, output blk_data, input  blk_ready);
    modport slave  (input  blk_valid, input  blk_data, output blk_ready);

endinterface
`default_nettype wire

// File: rtl/ccff_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : ccff_phase_timer
// Description : Low/high phase sequencer for the programming clock.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_phase_timer #(
    parameter int HALF_CYC = 1
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_phase_end,
    output logic      o_phase_high
);

    logic [7:0] r_cnt;
    logic       r_high;

    assign o_phase_end  = i_en && (r_cnt == 8'(HALF_CYC - 1));
    assign o_phase_high = r_high;

    // Disabled means frozen: a starved chain keeps its current phase position.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt  <= 8'd0;
            r_high <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= 8'd0;
            r_high <= 1'b0;
        end else if (o_phase_end) begin
            r_cnt  <= 8'd0;
            r_high <= ~r_high;
        end else if (i_en) begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccff_block_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ccff_block_serializer
// Description : Serializes decrypted blocks onto the FPGA config chain head.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_block_serializer
    import pmu_cfg_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int HALF_CYC   = 1,
    parameter int PRESET_CYC = 4
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    input  wire logic               start_i,
    input  wire logic [CNT_W-1:0]   bit_count_i,
    ccff_block_serializer_if.slave  blk,
    output logic                    data_o,
    output logic                    progclk_o,
    output logic                    preset_o,
    output logic                    busy_o,
    output logic                    starve_o,
    output logic                    done_o
);

    ser_state_e          r_state;
    logic [CNT_W-1:0]    r_remaining;
    logic [BITS_W-1:0]   r_bits;
    logic [BLOCK_W-1:0]  r_shreg;
    logic [BLOCK_W-1:0]  r_buf;
    logic                r_buf_vld;
    logic [7:0]          r_pre_cnt;
    logic                r_data;
    logic                r_preset;
    logic                r_busy;
    logic                r_done;

    logic w_in_flow, w_accept, w_xfer, w_shift, w_tmr_en, w_tmr_clr;
    logic w_phase_end, w_phase_high;

    // Only request a block while the bits still owed exceed those already queued.
    assign w_in_flow     = (r_state == ST_PRESET) || (r_state == ST_SHIFT);
    assign blk.blk_ready = w_in_flow && !r_buf_vld && (r_remaining > CNT_W'(r_bits));
    assign w_accept      = blk.blk_valid && blk.blk_ready;

    assign w_xfer    = (r_state == ST_SHIFT) && (r_bits == '0) && r_buf_vld && (r_remaining != '0);
    assign w_tmr_en  = (r_state == ST_SHIFT) && (r_bits != '0) && (r_remaining != '0);
    assign w_tmr_clr = (r_state != ST_SHIFT);
    assign w_shift   = w_phase_end && w_phase_high;

    ccff_phase_timer #(
        .HALF_CYC (HALF_CYC)
    ) u_phase_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_clr        (w_tmr_clr),
        .i_en         (w_tmr_en),
        .o_phase_end  (w_phase_end),
        .o_phase_high (w_phase_high)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_bits      <= '0;
            r_shreg     <= '0;
            r_buf       <= '0;
            r_buf_vld   <= 1'b0;
            r_pre_cnt   <= 8'd0;
            r_data      <= 1'b0;
            r_preset    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_buf     <= blk.blk_data;
                r_buf_vld <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_remaining <= bit_count_i;
                        r_pre_cnt   <= 8'd0;
                        r_preset    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_PRESET;
                    end
                end
                ST_PRESET: begin
                    if (r_pre_cnt == 8'(PRESET_CYC - 1)) begin
                        r_preset <= 1'b0;
                        if (r_remaining == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (r_remaining == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_xfer) begin
                        r_shreg   <= r_buf;
                        r_bits    <= BITS_W'(BLOCK_W);
                        r_buf_vld <= 1'b0;
                        r_data    <= r_buf[0];
                    end else if (w_shift) begin
                        r_shreg     <= r_shreg >> 1;
                        r_bits      <= r_bits - BITS_W'(1);
                        r_remaining <= r_remaining - CNT_W'(1);
                        // Present the next bit only if it will actually be clocked.
                        if ((r_bits > BITS_W'(1)) && (r_remaining > CNT_W'(1))) begin
                            r_data <= r_shreg[1];
                        end
                    end
                end
                ST_DONE: begin
                    r_buf_vld <= 1'b0;
                    r_bits    <= '0;
                    r_data    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_o    = r_data;
    assign progclk_o = w_phase_high;
    assign preset_o  = r_preset;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign starve_o  = (r_state == ST_SHIFT) && (r_remaining != '0) && (r_bits == '0) && !r_buf_vld;

endmodule
`default_nettype wire
